// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: responder end of the core's fetch and data channels.
// Single-port word RAM with a fixed response latency and traffic counters.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] cnt_inst,
  output logic [31:0] cnt_read,
  output logic [31:0] cnt_write,
  output logic [31:0] cnt_busy
);

  typedef enum logic [2:0] {
    IDLE, I_WAIT, I_RESP, R_WAIT, R_RESP, W_WAIT
  } state_t;

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_t                state;
  logic [3:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] d_idx;
  logic [ADDR_WIDTH-1:0] i_idx;
  logic                  wr_go;
  logic                  rd_go;
  logic                  if_go;
  logic                  unused_addr;

  assign d_idx = Address[ADDR_WIDTH+1:2];
  assign i_idx = PC[ADDR_WIDTH+1:2];

  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0],
                         PC[31:ADDR_WIDTH+2], PC[1:0]};

  assign Mem_Req_Ready  = (state == IDLE) & ~rst;
  assign Inst_Req_Ready = Mem_Req_Ready & ~MemRead & ~MemWrite;

  assign wr_go = Mem_Req_Ready & MemWrite;
  assign rd_go = Mem_Req_Ready & MemRead & ~MemWrite;
  assign if_go = Inst_Req_Ready & Inst_Req_Valid;

  // Byte-strobed write, committed on the accepting edge
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem[d_idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM: accept, wait out latency, present response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      lat_cnt         <= '0;
      idx             <= '0;
      Instruction     <= '0;
      Inst_Valid      <= 1'b0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
      cnt_inst        <= '0;
      cnt_read        <= '0;
      cnt_write       <= '0;
      cnt_busy        <= '0;
    end else begin
      if (state != IDLE) begin
        cnt_busy <= cnt_busy + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (wr_go) begin
            lat_cnt   <= LAT;
            cnt_write <= cnt_write + 32'd1;
            state     <= W_WAIT;
          end else if (rd_go) begin
            idx     <= d_idx;
            lat_cnt <= LAT;
            state   <= R_WAIT;
          end else if (if_go) begin
            idx     <= i_idx;
            lat_cnt <= LAT;
            state   <= I_WAIT;
          end
        end
        I_WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            Instruction <= mem[idx];
            Inst_Valid  <= 1'b1;
            state       <= I_RESP;
          end
        end
        I_RESP: begin
          if (Inst_Ready) begin
            Inst_Valid <= 1'b0;
            cnt_inst   <= cnt_inst + 32'd1;
            state      <= IDLE;
          end
        end
        R_WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            Read_data       <= mem[idx];
            Read_data_Valid <= 1'b1;
            state           <= R_RESP;
          end
        end
        R_RESP: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            cnt_read        <= cnt_read + 32'd1;
            state           <= IDLE;
          end
        end
        W_WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: random and directed traffic against a
// transaction-level model of memory contents, timing and counters.
module tb_cpu_mem_responder;

  localparam int AW = 12;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC = '0;
  logic        Inst_Req_Valid = 1'b0;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b0;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic [31:0] cnt_inst;
  logic [31:0] cnt_read;
  logic [31:0] cnt_write;
  logic [31:0] cnt_busy;

  cpu_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid),
    .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .cnt_inst(cnt_inst), .cnt_read(cnt_read),
    .cnt_write(cnt_write), .cnt_busy(cnt_busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] ram_m [0:(1<<AW)-1];
  logic [31:0] e_inst  = '0;
  logic [31:0] e_read  = '0;
  logic [31:0] e_write = '0;
  logic [31:0] e_busy  = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt;
    chk("cnt_inst", cnt_inst, e_inst);
    chk("cnt_read", cnt_read, e_read);
    chk("cnt_write", cnt_write, e_write);
    chk("cnt_busy", cnt_busy, e_busy);
  endtask

  task automatic clr_model_cnt;
    e_inst = '0; e_read = '0; e_write = '0; e_busy = '0;
  endtask

  // write: busy for L+1 cycles, no response channel
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit with_rd);
    int w;
    Address = a; Write_data = d; Write_strb = s;
    MemWrite = 1'b1; MemRead = with_rd;
    #1;
    chk("wr_accept", Mem_Req_Ready, 1);
    w = widx(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) ram_m[w][8*b +: 8] = d[8*b +: 8];
    tick;
    MemWrite = 1'b0; MemRead = 1'b0;
    Address = $urandom; Write_data = $urandom; Write_strb = 4'($urandom);
    for (int i = 0; i <= L; i++) begin
      chk("wr_busy", Mem_Req_Ready, 0);
      if (with_rd) chk("wr_no_rvalid", Read_data_Valid, 0);
      tick;
    end
    chk("wr_done", Mem_Req_Ready, 1);
    e_write++;
    e_busy += L + 1;
    chk_cnt();
  endtask

  // read or fetch: valid L+1 cycles after accept, held for 'hold' stalls
  task automatic do_rd(input bit inst, input logic [31:0] a,
                       input int hold);
    logic [31:0] exp;
    exp = ram_m[widx(a)];
    if (inst) begin
      PC = a; Inst_Req_Valid = 1'b1;
    end else begin
      Address = a; MemRead = 1'b1;
    end
    #1;
    chk(inst ? "if_accept" : "rd_accept",
        inst ? Inst_Req_Ready : Mem_Req_Ready, 1);
    tick;
    if (inst) begin
      Inst_Req_Valid = 1'b0; PC = $urandom;
    end else begin
      MemRead = 1'b0; Address = $urandom;
    end
    for (int i = 0; i <= L; i++) begin
      chk("wait_novalid", inst ? Inst_Valid : Read_data_Valid, 0);
      tick;
    end
    chk("resp_valid", inst ? Inst_Valid : Read_data_Valid, 1);
    chk("resp_data", inst ? Instruction : Read_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", inst ? Inst_Valid : Read_data_Valid, 1);
      chk("hold_data", inst ? Instruction : Read_data, exp);
    end
    if (inst) Inst_Ready = 1'b1;
    else      Read_data_Ready = 1'b1;
    tick;
    Inst_Ready = 1'b0; Read_data_Ready = 1'b0;
    chk("resp_clear", inst ? Inst_Valid : Read_data_Valid, 0);
    chk("data_keep", inst ? Instruction : Read_data, exp);
    if (inst) e_inst++;
    else      e_read++;
    e_busy += L + 2 + hold;
    chk_cnt();
  endtask

  task automatic release_rst;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_idle", Mem_Req_Ready, 1);
    clr_model_cnt();
  endtask

  initial begin
    logic [31:0] a;
    int          op;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ivalid", Inst_Valid, 0);
    chk("rst_rvalid", Read_data_Valid, 0);
    chk("rst_inst", Instruction, 0);
    chk("rst_rdata", Read_data, 0);
    chk("rst_mready", Mem_Req_Ready, 0);
    chk_cnt();
    rst = 1'b0;

    for (int w = 0; w < 16; w++)
      do_write(32'(w) << 2, $urandom, 4'hF, 1'b0);
    do_write(32'h0, 32'h0000_0013, 4'hF, 1'b0);
    do_write(32'h104, 32'h1122_3344, 4'hF, 1'b0);

    do_rd(1'b1, 32'h0, 0);
    chk("tp_fetch0", Instruction, 32'h0000_0013);

    do_write(32'h104, 32'hAABB_CCDD, 4'b0110, 1'b0);
    do_rd(1'b0, 32'h104, 0);
    chk("tp_strb", Read_data, 32'h11BB_CC44);

    PC = 32'h0; Inst_Req_Valid = 1'b1;
    Address = 32'h104; MemRead = 1'b1;
    #1;
    chk("prio_if_block", Inst_Req_Ready, 0);
    do_rd(1'b0, 32'h104, 0);
    chk("prio_if_after", Inst_Req_Ready, 1);
    do_rd(1'b1, 32'h0, 0);

    do_rd(1'b0, 32'h8, 5);

    do_write(32'h8, 32'h5A5A_1234, 4'hF, 1'b0);
    do_rd(1'b0, 32'h0000_4008, 0);
    chk("wrap_rd", Read_data, 32'h5A5A_1234);
    do_write(32'h0000_4008, 32'h0BAD_BEEF, 4'hF, 1'b1);
    do_rd(1'b0, 32'h8, 0);
    chk("wr_wins", Read_data, 32'h0BAD_BEEF);

    for (int n = 0; n < 150; n++) begin
      a  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2)
         | ($urandom & 32'h3);
      op = $urandom_range(0, 2);
      if (op == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
      else
        do_rd(op == 1, a, $urandom_range(0, 3));
    end

    do_write(32'h14, 32'hCAFE_F00D, 4'hF, 1'b0);
    PC = 32'h0; Inst_Req_Valid = 1'b1;
    tick;
    Inst_Req_Valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_ivalid", Inst_Valid, 0);
    chk("rstw_iready", Inst_Req_Ready, 0);
    clr_model_cnt();
    chk_cnt();
    release_rst();
    do_rd(1'b0, 32'h14, 0);
    chk("rst_ram_keep", Read_data, 32'hCAFE_F00D);

    PC = 32'h0; Inst_Req_Valid = 1'b1;
    tick;
    Inst_Req_Valid = 1'b0;
    repeat (L + 1) tick;
    chk("rstr_pre", Inst_Valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstr_ivalid", Inst_Valid, 0);
    chk("rstr_inst", Instruction, 0);
    release_rst();
    do_rd(1'b1, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Responder (slave) end of the CPU's instruction-fetch and data-memory valid/ready channels. It owns a single-port word-addressed RAM and serves one transaction at a time, with a programmable fixed response latency. It sits between the multi-cycle RISC-V core and simulation/FPGA memory, and replaces the ideal memory model so that core stall behaviour can be exercised. It also exports traffic counters for the performance-counter bank.

Parameters:
ADDR_WIDTH, 12, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits
LATENCY, 2, wait cycles between request acceptance and response/ready-to-accept (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
PC  input  32  instruction fetch byte address
Inst_Req_Valid  input  1  fetch request valid
Inst_Req_Ready  output  1  fetch request accepted when high with valid
Instruction  output  32  fetched word
Inst_Valid  output  1  Instruction valid
Inst_Ready  input  1  core accepts Instruction
Address  input  32  data byte address (low 2 bits ignored)
MemWrite  input  1  write request valid
Write_data  input  32  write data, byte lanes pre-aligned by core
Write_strb  input  4  byte enables, bit i = bits [8i+7:8i]
MemRead  input  1  read request valid
Mem_Req_Ready  output  1  data request accepted when high with MemRead or MemWrite
Read_data  output  32  read word (unaligned extraction done by core)
Read_data_Valid  output  1  Read_data valid
Read_data_Ready  input  1  core accepts Read_data
cnt_inst  output  32  completed fetch responses
cnt_read  output  32  completed read responses
cnt_write  output  32  accepted writes
cnt_busy  output  32  cycles in any non-IDLE state

Behaviour:
- Reset (async, rst=1): state=IDLE; Inst_Valid=0, Read_data_Valid=0, Instruction=0, Read_data=0, all counters=0, latency counter=0. RAM contents are not reset.
- Readies are combinational:
  - Mem_Req_Ready = (state==IDLE) & ~rst
  - Inst_Req_Ready = (state==IDLE) & ~rst & ~MemRead & ~MemWrite
  - Data requests have strict priority over fetch.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- States: IDLE, I_WAIT, I_RESP, R_WAIT, R_RESP, W_WAIT.
- IDLE:
  - MemWrite handshake: commit the strobed bytes to RAM at this edge, load counter=LATENCY, go to W_WAIT. If MemRead is also high, the write wins and the read is ignored.
  - Otherwise MemRead handshake: latch the index, load counter, go to R_WAIT.
  - Otherwise Inst_Req_Valid handshake: latch the index, load counter, go to I_WAIT.
- I_WAIT / R_WAIT:
  - While counter!=0, decrement.
  - When counter==0: at that edge, register RAM[latched index] into Instruction or Read_data, set the matching valid, and go to I_RESP or R_RESP.
  - LATENCY=0 therefore gives the response one cycle after acceptance; general latency is acceptance-to-valid = LATENCY+1 cycles.
- I_RESP / R_RESP:
  - Hold valid and data stable until the ready input is high.
  - On valid&ready: clear valid, increment cnt_inst or cnt_read, return to IDLE.
  - Data registers keep their last value after valid clears.
- W_WAIT: decrement the counter; when it is 0, go to IDLE. No response channel for writes.
- Counters:
  - cnt_write increments on write acceptance.
  - cnt_busy increments each cycle that state!=IDLE.
  - All counters wrap at 2**32.
- Read-after-write to the same word returns the new data, because the write was committed at acceptance.
- Reset mid-transaction: abort immediately, valids drop asynchronously, and an already-accepted write stays committed.
- Inputs are sampled only on handshake. Request-side changes while busy are ignored.

Test Plan:
- LATENCY=2, RAM[0]=0x00000013; PC=0, Inst_Req_Valid pulse -> accepted in IDLE, Inst_Valid rises 3 cycles later with Instruction=0x00000013; Inst_Ready=1 -> valid clears, cnt_inst=1.
- Write Address=0x104, Write_data=0xAABBCCDD, strb=4'b0110 onto RAM[0x41]=0x11223344 -> then read 0x104 returns 0x11BBCC44; cnt_write=1, cnt_read=1.
- MemRead and Inst_Req_Valid asserted together in IDLE -> Inst_Req_Ready=0 and the read is served first; after return to IDLE the fetch is accepted.
- Hold Read_data_Ready=0 for 5 cycles during R_RESP -> Read_data_Valid and Read_data stay constant, state does not advance, cnt_busy counts those cycles.
- Address=0x00004008 with ADDR_WIDTH=12 -> accesses word 2 (wrap); MemRead and MemWrite high together -> write only, no Read_data_Valid.
- Assert rst during I_WAIT after a write to word 5 -> Inst_Valid=0 immediately, state=IDLE, counters=0, RAM[5] keeps the written value.
